uart_tx_core: RTL and testbench
===============================

Name: uart_tx_core

Overview:
- Serial transmitter that forms the other end of the UART receive path.
- Accepts a parallel word over a valid/ready handshake and shifts it out as a standard asynchronous frame: start bit, data bits LSB first, optional parity bit, then stop bit(s).
- Bit timing comes from an internal clock-cycle divider.
- Sits between the core-side data source and the tx pad.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range is 2 or more.
- DATA_W, 8, data bits per frame; legal range is 5..9.
- STOP_BITS, 1, number of stop bits; legal values are 1 or 2.
- PARITY_ODD, 0, parity sense; 1 selects odd, 0 selects even. Used only when UART_TX_PARITY_EN is defined.

Ports:
- clk  input  1  system clock; all logic on posedge.
- nReset  input  1  synchronous, active-low reset, sampled on posedge clk.
- data  input  DATA_W  word to transmit; sampled only on accept.
- valid  input  1  source has a word on data.
- ready  output  1  block can accept a word this cycle.
- tx  output  1  serial line; idle is high.
- busy  output  1  a frame is in progress; equals ~ready.
- done  output  1  one-cycle pulse in the final cycle of the last stop bit.

Behaviour:
- Reset: one clock; reset is synchronous and active-low. nReset low at a posedge sets:
  - state = IDLE
  - tx = 1, ready = 1, busy = 0, done = 0
  - all counters and the shift register = 0
- Reset mid-frame: the frame aborts immediately. tx returns high the next cycle; no partial frame resumes.
- Handshake:
  - Accept happens when valid & ready at a posedge. data is latched into the shift register.
  - ready is high only in IDLE.
  - valid while ready is low is ignored; no queuing.
  - data changes after accept have no effect on the frame in flight.
- Outputs are registered:
  - tx goes low in the cycle after accept.
  - ready drops in the cycle after accept.
- State machine, each bit state lasting exactly CLKS_PER_BIT cycles via counter cyc (0..CLKS_PER_BIT-1):
  - IDLE: tx = 1. On accept go to START.
  - START: tx = 0. When cyc wraps go to DATA with bit index = 0.
  - DATA: tx = shift[0]. On cyc wrap, shift right and increment bit index. After bit DATA_W-1 go to PARITY if enabled, otherwise STOP.
  - PARITY: tx = parity bit (see Optional Feature). On wrap go to STOP.
  - STOP: tx = 1 for STOP_BITS*CLKS_PER_BIT cycles. done = 1 in the final cycle, then go to IDLE.
- Frame length, accept to ready re-high: (1 + DATA_W + P + STOP_BITS)*CLKS_PER_BIT + 1 cycles, where P = 1 with parity, 0 without.
- Back-to-back frames: the minimum gap is one extra idle-high clock between frames. This is intentional and keeps ready purely state-decoded.
- Widths:
  - cyc is $clog2(CLKS_PER_BIT) bits and wraps to 0 at CLKS_PER_BIT-1. No other overflow is possible.
  - The bit index is $clog2(DATA_W+1) bits.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted after DATA.
  - Parity bit = ^data_latched ^ PARITY_ODD, computed at accept and held.
  - The frame gains CLKS_PER_BIT cycles.
- Undefined: no PARITY state, no parity register; PARITY_ODD is ignored.

Decomposition:
- Package uart_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, PARITY, STOP)
  - the default CLKS_PER_BIT and DATA_W constants
  - a frame-length helper function used by both RTL and bench
- One sub-module: uart_tx_baud_cnt.
  - Inputs: clk, nReset, clear (asserted on accept and on state change).
  - Output: bit_tick, high on the last cycle of each bit period.
  - The FSM advances only on bit_tick.

Test Plan:
- Reset: hold nReset low 3 cycles with valid = 1 -> tx = 1, ready = 1, done = 0 throughout. No accept until the cycle after nReset rises.
- Basic frame (CLKS_PER_BIT = 4, DATA_W = 8, no parity), data 0xA5 accepted at cycle 0:
  - tx low cycles 1-4.
  - Bits 1,0,1,0,0,1,0,1 for 4 cycles each, cycles 5-36.
  - tx high cycles 37-40; done pulses at cycle 40; ready high at cycle 41.
- Parity (macro defined, PARITY_ODD = 0), data 0xA5:
  - Parity bit 0 on cycles 37-40, stop bit on 41-44.
  - Same with data 0x07 -> parity bit 1.
- Busy ignore: data 0x3C accepted; at cycle 10 drive valid = 1 with data 0xFF -> no accept. Serialized bits remain 0x3C. ready stays low until the frame ends.
- Back-to-back: valid held high with 0x01 then 0x80 -> second accept occurs the cycle ready reasserts. tx shows exactly one idle-high clock between the two frames.
- Reset mid-frame: nReset low during DATA bit 3 -> next cycle tx = 1, ready = 1. A fresh 0x55 frame afterwards is bit-exact.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type, default sizes and frame-length helper for the UART transmitter
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int DEFAULT_DATA_W       = 8;

  // Clock cycles from the accepting edge until ready is high again.
  function automatic int frame_cycles(input int clks_per_bit, input int data_w,
                                      input int stop_bits, input int parity_bits);
    return (1 + data_w + parity_bits + stop_bits) * clks_per_bit + 1;
  endfunction

endpackage

// File: rtl/uart_tx_baud_cnt.sv
// rtl/uart_tx_baud_cnt.sv - bit-period divider; bit_tick marks the last clock of each serial bit
module uart_tx_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic nReset,
  input  logic clear,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cyc_q, cyc_d;

  assign bit_tick = (cyc_q == LAST);

  // Count 0..CLKS_PER_BIT-1; a clear restarts the period so every bit state gets a full period.
  always_comb begin
    cyc_d = cyc_q + 1'b1;
    if (clear || bit_tick) begin
      cyc_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - UART transmitter FSM; parity state present only when UART_TX_PARITY_EN is defined
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int IW = $clog2(DATA_W + 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_W - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              tx_q, tx_d;
  logic              accept;
  logic              clear;
  logic              bit_tick;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD[0];
`endif

  // ready is decoded from state alone, which costs one idle clock between frames.
  assign ready  = (state_q == IDLE);
  assign busy   = ~ready;
  assign accept = valid & ready;
  assign tx     = tx_q;
  assign done   = (state_q == STOP) && bit_tick && (idx_q == LAST_STOP);

  // Restart the bit period whenever a new state begins.
  assign clear = accept | (state_d != state_q);

  uart_tx_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .nReset  (nReset),
    .clear   (clear),
    .bit_tick(bit_tick)
  );

  // Next-state logic: all bit states advance only on bit_tick.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shift_d = data;
          idx_d   = '0;
`ifdef UART_TX_PARITY_EN
          par_d   = (^data) ^ PARITY_ODD[0];
`endif
        end
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_DATA) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
          idx_d   = '0;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          if (idx_q == LAST_STOP) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Line level for the coming cycle, taken from the next state so tx is a clean flop output.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset aborts any frame and drives the line idle.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb/tb_uart_tx_core.sv - self-checking bench for uart_tx_core with a frame-level reference model
module tb_uart_tx_core;
  import uart_pkg::*;

  localparam int CLKS = 4;
  localparam int DW   = 8;
  localparam int SB   = 1;
  localparam int ODD  = 0;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int L = frame_cycles(CLKS, DW, SB, PB);
  localparam logic ODD_BIT = (ODD != 0);

  logic          clk = 1'b0;
  logic          nReset = 1'b0;
  logic [DW-1:0] data = '0;
  logic          valid = 1'b0;
  logic          ready, tx, busy, done;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS),
    .DATA_W      (DW),
    .STOP_BITS   (SB),
    .PARITY_ODD  (ODD)
  ) dut (
    .clk   (clk),
    .nReset(nReset),
    .data  (data),
    .valid (valid),
    .ready (ready),
    .tx    (tx),
    .busy  (busy),
    .done  (done)
  );

  // Model: m_k = clocks elapsed since the accepting edge, -1 when idle.
  int            m_k = -1;
  logic [DW-1:0] m_word = '0;
  bit            m_live = 1'b0;
  int            cyc_n = 0;

  function automatic logic frame_bit(input logic [DW-1:0] w, input int b);
    if (b == 0) return 1'b0;
    if (b <= DW) return w[b-1];
    if (PB == 1 && b == DW + 1) return (^w) ^ ODD_BIT;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    cyc_n  <= cyc_n + 1;
    m_live <= 1'b1;
    if (!nReset) begin
      m_k <= -1;
    end else if (m_k < 0) begin
      if (valid) begin
        m_k    <= 1;
        m_word <= data;
      end
    end else begin
      m_k <= (m_k + 1 >= L) ? -1 : m_k + 1;
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc_n, act, exp);
    end
  endtask

  // Every cycle: compare all outputs against the model's view of the frame.
  always @(negedge clk) begin
    if (m_live) begin
      logic exp_idle, exp_tx, exp_done;
      exp_idle = (m_k < 0);
      exp_tx   = exp_idle ? 1'b1 : frame_bit(m_word, (m_k - 1) / CLKS);
      exp_done = !exp_idle && (m_k == L - 1);
      chk("model_tx", tx, exp_tx);
      chk("model_ready", ready, exp_idle);
      chk("model_busy", busy, !exp_idle);
      chk("model_done", done, exp_done);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (m_k >= 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (m_k >= 0) begin
      n_err++;
      $display("FAIL wait_idle: frame did not end within 200 cycles");
    end
    @(negedge clk);
  endtask

  // Present a word while idle; returns at the negedge of frame cycle 1.
  task automatic send_frame(input logic [DW-1:0] w);
    valid = 1'b1;
    data  = w;
    @(negedge clk);
    valid = 1'b0;
    data  = DW'($urandom);
  endtask

  initial begin
    // Reset held three cycles with valid asserted.
    nReset = 1'b0;
    valid  = 1'b1;
    data   = 8'h5A;
    repeat (3) begin
      @(negedge clk);
      chk("rst_tx", tx, 1'b1);
      chk("rst_ready", ready, 1'b1);
      chk("rst_done", done, 1'b0);
    end
    nReset = 1'b1;
    @(negedge clk);
    chk("post_rst_accept_ready", ready, 1'b0);
    chk("post_rst_accept_tx", tx, 1'b0);
    valid = 1'b0;
    wait_idle();

    // Basic 0xA5 frame, bits 1,0,1,0,0,1,0,1.
    send_frame(8'hA5);
    for (int c = 1; c <= L + 1; c++) begin
      if (c == 1) chk("a5_c1_start", tx, 1'b0);
      if (c == 4) chk("a5_c4_start", tx, 1'b0);
      if (c == 6) chk("a5_c6_bit0", tx, 1'b1);
      if (c == 10) chk("a5_c10_bit1", tx, 1'b0);
      if (c == 22) chk("a5_c22_bit4", tx, 1'b0);
      if (c == 34) chk("a5_c34_bit7", tx, 1'b1);
`ifdef UART_TX_PARITY_EN
      if (c == 38) chk("a5_c38_parity", tx, 1'b0);
      if (c == 42) chk("a5_c42_stop", tx, 1'b1);
      if (c == 44) chk("a5_c44_done", done, 1'b1);
      if (c == 44) chk("a5_c44_ready", ready, 1'b0);
      if (c == 45) chk("a5_c45_ready", ready, 1'b1);
`else
      if (c == 38) chk("a5_c38_stop", tx, 1'b1);
      if (c == 39) chk("a5_c39_nodone", done, 1'b0);
      if (c == 40) chk("a5_c40_done", done, 1'b1);
      if (c == 40) chk("a5_c40_ready", ready, 1'b0);
      if (c == 41) chk("a5_c41_ready", ready, 1'b1);
`endif
      @(negedge clk);
    end
    wait_idle();

`ifdef UART_TX_PARITY_EN
    send_frame(8'h07);
    repeat (37) @(negedge clk);
    chk("p07_c38_parity", tx, 1'b1);
    wait_idle();
`endif

    // Busy ignore: 0x3C in flight, 0xFF offered at cycle 10.
    send_frame(8'h3C);
    repeat (9) @(negedge clk);
    valid = 1'b1;
    data  = 8'hFF;
    @(negedge clk);
    chk("busy_ignore_ready", ready, 1'b0);
    chk("busy_ignore_c11_bit1", tx, 1'b0);
    valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_ignore_c14_bit2", tx, 1'b1);
    wait_idle();

    // Back-to-back with valid held: one idle-high clock between frames.
    valid = 1'b1;
    data  = 8'h01;
    @(negedge clk);
    data = 8'h80;
    repeat (L - 1) @(negedge clk);
    chk("b2b_gap_tx", tx, 1'b1);
    chk("b2b_gap_ready", ready, 1'b1);
    @(negedge clk);
    chk("b2b_second_start_tx", tx, 1'b0);
    chk("b2b_second_ready", ready, 1'b0);
    valid = 1'b0;
    wait_idle();

    // Reset during DATA bit 3, then a clean 0x55 frame.
    send_frame(8'h33);
    repeat (17) @(negedge clk);
    nReset = 1'b0;
    @(negedge clk);
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_ready", ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    nReset = 1'b1;
    @(negedge clk);
    send_frame(8'h55);
    repeat (5) @(negedge clk);
    chk("r55_c6_bit0", tx, 1'b1);
    repeat (4) @(negedge clk);
    chk("r55_c10_bit1", tx, 1'b0);
    wait_idle();

    // Randomized traffic with occasional resets; the model checks every cycle.
    for (int i = 0; i < 4000; i++) begin
      valid  = ($urandom_range(0, 3) != 0);
      data   = DW'($urandom);
      nReset = ($urandom_range(0, 599) != 0);
      @(negedge clk);
    end
    nReset = 1'b1;
    valid  = 1'b0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
